// File: rtl/snoop_responder.sv
// MSI snoop responder: decodes a bus snoop, reads the local arrays through a borrowed port,
// answers hit/dirty/data in the response cycle and downgrades the hit way. Optional counters: SNOOP_STATS_EN.
module snoop_responder #(
    parameter int SETS  = 16,
    parameter int WAYS  = 4,
    parameter int TAG_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               bus_command_address,
    input  logic [2:0]                bus_command_command,
    input  logic                      self_owner,
    output logic                      snoop_busy,
    output logic [$clog2(SETS)-1:0]   arr_set,
    input  logic [TAG_W-1:0]          arr_tag_in   [WAYS],
    input  logic [1:0]                arr_state_in [WAYS],
    input  logic [255:0]              arr_data_in  [WAYS],
    output logic [WAYS-1:0]           arr_state_we,
    output logic [1:0]                arr_state_out,
    output logic                      snoop_hit,
    output logic                      snoop_dirty,
    output logic [255:0]              snoop_data,
    output logic [31:0]               snoop_hit_count,
    output logic [31:0]               snoop_inval_count
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int LINE_W = 27;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] CMD_RD   = 3'd1;
    localparam logic [2:0] CMD_RDX  = 3'd2;
    localparam logic [2:0] CMD_UPGR = 3'd3;
    localparam logic [2:0] CMD_FLSH = 3'd4;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_M = 2'd2;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND} state_e;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [2:0]          cmd_q, cmd_d;
    logic                cmd_valid;
    logic                start;
    logic [TAG_W-1:0]    tag_q;
    logic                hit_any;
    logic [WAY_W-1:0]    hit_way;
    logic [1:0]          hit_state;
    logic                wr_en;
    logic [1:0]          wr_val;
    logic                unused_addr_bits;

    // Byte offset within the 32-byte line plays no part in a snoop.
    assign unused_addr_bits = ^bus_command_address[4:0];

    assign cmd_valid = (bus_command_command >= CMD_RD) && (bus_command_command <= CMD_FLSH);
    assign start     = (state_q == IDLE) && cmd_valid && !self_owner;
    assign tag_q     = line_q[LINE_W-1 -: TAG_W];

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cmd_q   <= cmd_d;
        end
    end

    // NOTE: every variable gets a default before the case, otherwise paths that skip
    // an assignment would infer latches.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOOKUP;
                    line_d  = bus_command_address[31:5];
                    cmd_d   = bus_command_command;
                end
            end
            LOOKUP:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The cache must yield in the very cycle the snoop is accepted.
    assign snoop_busy = start || (state_q != IDLE);
    assign arr_set    = start              ? bus_command_address[5 +: IDX_W] :
                        (state_q != IDLE)  ? line_q[IDX_W-1:0] : '0;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any && (arr_tag_in[w] == tag_q) && (arr_state_in[w] != ST_I)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_state   = arr_state_in[hit_way];
    assign snoop_hit   = (state_q == RESPOND) && hit_any;
    assign snoop_dirty = snoop_hit && (hit_state == ST_M);
    assign snoop_data  = snoop_hit ? arr_data_in[hit_way] : '0;

    // A reset arriving in the response cycle must not leave a half-done state write.
    always_comb begin
        wr_en  = 1'b0;
        wr_val = ST_I;
        if (snoop_hit && !rst) begin
            case (cmd_q)
                CMD_RD: begin
                    if (hit_state == ST_M) begin
                        wr_en  = 1'b1;
                        wr_val = ST_S;
                    end
                end
                CMD_RDX, CMD_UPGR: begin
                    wr_en  = 1'b1;
                    wr_val = ST_I;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            arr_state_we[w] = wr_en && (hit_way == WAY_W'(w));
        end
    end
    assign arr_state_out = wr_en ? wr_val : ST_I;

`ifdef SNOOP_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] inval_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q   <= '0;
            inval_cnt_q <= '0;
        end else begin
            if (snoop_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (wr_en && (wr_val == ST_I) && (inval_cnt_q != '1)) begin
                inval_cnt_q <= inval_cnt_q + 32'd1;
            end
        end
    end

    assign snoop_hit_count   = hit_cnt_q;
    assign snoop_inval_count = inval_cnt_q;
`else
    assign snoop_hit_count   = '0;
    assign snoop_inval_count = '0;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder with a 1-cycle-latency SRAM model behind the array port.
module tb_snoop_responder;

    localparam int SETS  = 16;
    localparam int WAYS  = 4;
    localparam int TAG_W = 23;

    localparam logic [31:0] ADDR_A = 32'h0000_1240;  // set 2, tag 9
    localparam logic [31:0] ADDR_B = 32'h0000_2460;  // set 3, tag 18

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [31:0]          bus_command_address;
    logic [2:0]           bus_command_command;
    logic                 self_owner;
    logic                 snoop_busy;
    logic [3:0]           arr_set;
    logic [TAG_W-1:0]     arr_tag_in   [WAYS];
    logic [1:0]           arr_state_in [WAYS];
    logic [255:0]         arr_data_in  [WAYS];
    logic [WAYS-1:0]      arr_state_we;
    logic [1:0]           arr_state_out;
    logic                 snoop_hit;
    logic                 snoop_dirty;
    logic [255:0]         snoop_data;
    logic [31:0]          snoop_hit_count;
    logic [31:0]          snoop_inval_count;

    snoop_responder #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus_command_address (bus_command_address),
        .bus_command_command (bus_command_command),
        .self_owner          (self_owner),
        .snoop_busy          (snoop_busy),
        .arr_set             (arr_set),
        .arr_tag_in          (arr_tag_in),
        .arr_state_in        (arr_state_in),
        .arr_data_in         (arr_data_in),
        .arr_state_we        (arr_state_we),
        .arr_state_out       (arr_state_out),
        .snoop_hit           (snoop_hit),
        .snoop_dirty         (snoop_dirty),
        .snoop_data          (snoop_data),
        .snoop_hit_count     (snoop_hit_count),
        .snoop_inval_count   (snoop_inval_count)
    );

    // ---------------- array model ----------------
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    logic [1:0]       m_state [SETS][WAYS];
    logic [3:0]       rd_set_q;
    logic             cfg_clr, cfg_we;
    logic [3:0]       cfg_set;
    logic [1:0]       cfg_way;
    logic [TAG_W-1:0] cfg_tag;
    logic [1:0]       cfg_state;

    function automatic logic [255:0] line(input logic [3:0] s, input int w);
        logic [31:0] word;
        word = 32'hD000_0000 + 32'(s) * 32'd256 + 32'(w);
        return {8{word}};
    endfunction

    always @(posedge clk) begin
        if (cfg_clr) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    m_tag[s][w]   <= '0;
                    m_state[s][w] <= 2'd0;
                end
        end else begin
            if (cfg_we) begin
                m_tag[cfg_set][cfg_way]   <= cfg_tag;
                m_state[cfg_set][cfg_way] <= cfg_state;
            end
            for (int w = 0; w < WAYS; w++)
                if (arr_state_we[w]) m_state[arr_set][w] <= arr_state_out;
        end
        rd_set_q <= arr_set;
        for (int w = 0; w < WAYS; w++) begin
            arr_tag_in[w]   <= m_tag[arr_set][w];
            arr_state_in[w] <= m_state[arr_set][w];
        end
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) arr_data_in[w] = line(rd_set_q, w);
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic            c0_busy, c1_busy, c1_hit, c3_busy;
    logic [3:0]      c0_set, c1_set;
    logic            c2_hit, c2_dirty;
    logic [255:0]    c2_data;
    logic [WAYS-1:0] c2_we;
    logic [1:0]      c2_out;

    task automatic set_way(input logic [3:0] s, input logic [1:0] w,
                           input logic [TAG_W-1:0] t, input logic [1:0] st);
        @(negedge clk);
        cfg_set = s; cfg_way = w; cfg_tag = t; cfg_state = st; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Drives one snoop (command held for cycles 0 and 1) and records what each cycle showed.
    task automatic run_snoop(input logic [31:0] addr, input logic [2:0] cmd, input logic own);
        @(negedge clk);
        bus_command_address = addr; bus_command_command = cmd; self_owner = own;
        #1 c0_busy = snoop_busy; c0_set = arr_set;
        @(negedge clk);
        #1 c1_busy = snoop_busy; c1_set = arr_set; c1_hit = snoop_hit;
        @(negedge clk);
        bus_command_command = 3'd0; self_owner = 1'b0;
        #1 c2_hit = snoop_hit; c2_dirty = snoop_dirty; c2_data = snoop_data;
        c2_we = arr_state_we; c2_out = arr_state_out;
        @(negedge clk);
        #1 c3_busy = snoop_busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; cfg_clr = 1'b1; cfg_we = 1'b0;
        bus_command_address = '0; bus_command_command = 3'd0; self_owner = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; cfg_clr = 1'b0;
        #1;
        checks++; if (snoop_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b exp 0", snoop_busy); end
        checks++; if (arr_set !== 4'd0) begin errors++; $display("FAIL reset arr_set: got %0d exp 0", arr_set); end
        checks++; if (snoop_hit !== 1'b0 || snoop_dirty !== 1'b0) begin errors++; $display("FAIL reset hit/dirty: got %b/%b exp 0/0", snoop_hit, snoop_dirty); end
        checks++; if (snoop_data !== '0) begin errors++; $display("FAIL reset data: got %h exp 0", snoop_data); end
        checks++; if (arr_state_we !== 4'b0 || arr_state_out !== 2'd0) begin errors++; $display("FAIL reset we/out: got %b/%0d exp 0/0", arr_state_we, arr_state_out); end
        checks++; if (snoop_hit_count !== 32'd0 || snoop_inval_count !== 32'd0) begin errors++; $display("FAIL reset counters: got %0d/%0d exp 0/0", snoop_hit_count, snoop_inval_count); end
    endtask

    task automatic test_rd_shared;
        set_way(4'd2, 2'd1, 23'd9, 2'd1);
        run_snoop(ADDR_A, 3'd1, 1'b0);
        checks++; if (c0_busy !== 1'b1 || c0_set !== 4'd2) begin errors++; $display("FAIL rd_s cycle0 busy/set: got %b/%0d exp 1/2", c0_busy, c0_set); end
        checks++; if (c1_busy !== 1'b1 || c1_set !== 4'd2 || c1_hit !== 1'b0) begin errors++; $display("FAIL rd_s cycle1 busy/set/hit: got %b/%0d/%b exp 1/2/0", c1_busy, c1_set, c1_hit); end
        checks++; if (c2_hit !== 1'b1 || c2_dirty !== 1'b0) begin errors++; $display("FAIL rd_s hit/dirty: got %b/%b exp 1/0", c2_hit, c2_dirty); end
        checks++; if (c2_data !== line(4'd2, 1)) begin errors++; $display("FAIL rd_s data: got %h exp %h", c2_data, line(4'd2, 1)); end
        checks++; if (c2_we !== 4'b0000) begin errors++; $display("FAIL rd_s we: got %b exp 0000", c2_we); end
        checks++; if (c3_busy !== 1'b0) begin errors++; $display("FAIL rd_s cycle3 busy: got %b exp 0", c3_busy); end
    endtask

    task automatic test_rd_modified;
        set_way(4'd2, 2'd1, 23'd9, 2'd0);
        set_way(4'd2, 2'd3, 23'd9, 2'd2);
        run_snoop(ADDR_A, 3'd1, 1'b0);
        checks++; if (c2_hit !== 1'b1 || c2_dirty !== 1'b1) begin errors++; $display("FAIL rd_m hit/dirty: got %b/%b exp 1/1", c2_hit, c2_dirty); end
        checks++; if (c2_data !== line(4'd2, 3)) begin errors++; $display("FAIL rd_m data: got %h exp %h", c2_data, line(4'd2, 3)); end
        checks++; if (c2_we !== 4'b1000 || c2_out !== 2'd1) begin errors++; $display("FAIL rd_m we/out: got %b/%0d exp 1000/1", c2_we, c2_out); end
        checks++; if (m_state[2][3] !== 2'd1) begin errors++; $display("FAIL rd_m stored state: got %0d exp 1", m_state[2][3]); end
    endtask

    task automatic test_multi_hit_flush;
        set_way(4'd2, 2'd0, 23'd9, 2'd1);
        set_way(4'd2, 2'd2, 23'd9, 2'd2);
        run_snoop(ADDR_A, 3'd4, 1'b0);
        checks++; if (c2_hit !== 1'b1 || c2_dirty !== 1'b0) begin errors++; $display("FAIL multi hit/dirty: got %b/%b exp 1/0", c2_hit, c2_dirty); end
        checks++; if (c2_data !== line(4'd2, 0)) begin errors++; $display("FAIL multi data: got %h exp %h", c2_data, line(4'd2, 0)); end
        checks++; if (c2_we !== 4'b0000) begin errors++; $display("FAIL flush we: got %b exp 0000", c2_we); end
    endtask

    task automatic test_rdx;
        set_way(4'd3, 2'd0, 23'd18, 2'd1);
        run_snoop(ADDR_B, 3'd2, 1'b0);
        checks++; if (c0_set !== 4'd3) begin errors++; $display("FAIL rdx set: got %0d exp 3", c0_set); end
        checks++; if (c2_hit !== 1'b1 || c2_data !== line(4'd3, 0)) begin errors++; $display("FAIL rdx hit/data: got %b/%h exp 1/%h", c2_hit, c2_data, line(4'd3, 0)); end
        checks++; if (c2_we !== 4'b0001 || c2_out !== 2'd0) begin errors++; $display("FAIL rdx we/out: got %b/%0d exp 0001/0", c2_we, c2_out); end
        run_snoop(ADDR_B, 3'd2, 1'b0);
        checks++; if (c2_hit !== 1'b0 || c2_data !== '0) begin errors++; $display("FAIL rdx repeat hit/data: got %b/%h exp 0/0", c2_hit, c2_data); end
        checks++; if (c2_we !== 4'b0000) begin errors++; $display("FAIL rdx repeat we: got %b exp 0000", c2_we); end
    endtask

    task automatic test_upgr;
        run_snoop(ADDR_A, 3'd3, 1'b0);
        checks++; if (c2_hit !== 1'b1 || c2_we !== 4'b0001 || c2_out !== 2'd0) begin errors++; $display("FAIL upgr hit/we/out: got %b/%b/%0d exp 1/0001/0", c2_hit, c2_we, c2_out); end
    endtask

    task automatic test_ignored_cmds;
        run_snoop(ADDR_A, 3'd1, 1'b1);
        checks++; if (c0_busy !== 1'b0 || c1_busy !== 1'b0) begin errors++; $display("FAIL self_owner busy: got %b/%b exp 0/0", c0_busy, c1_busy); end
        checks++; if (c0_set !== 4'd0 || c2_hit !== 1'b0) begin errors++; $display("FAIL self_owner set/hit: got %0d/%b exp 0/0", c0_set, c2_hit); end
        run_snoop(ADDR_A, 3'd7, 1'b0);
        checks++; if (c0_busy !== 1'b0 || c2_hit !== 1'b0) begin errors++; $display("FAIL cmd7 busy/hit: got %b/%b exp 0/0", c0_busy, c2_hit); end
    endtask

    task automatic test_back_to_back;
        // Set 2 now holds way2 = M, way3 = S; the held command retriggers after RESPOND.
        @(negedge clk);
        bus_command_address = ADDR_A; bus_command_command = 3'd1; self_owner = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (snoop_hit !== 1'b1 || snoop_dirty !== 1'b1 || arr_state_we !== 4'b0100 || arr_state_out !== 2'd1) begin
            errors++; $display("FAIL b2b first hit/dirty/we/out: got %b/%b/%b/%0d exp 1/1/0100/1", snoop_hit, snoop_dirty, arr_state_we, arr_state_out); end
        checks++; if (snoop_data !== line(4'd2, 2)) begin errors++; $display("FAIL b2b first data: got %h exp %h", snoop_data, line(4'd2, 2)); end
        @(negedge clk);
        #1;
        checks++; if (snoop_busy !== 1'b1 || snoop_hit !== 1'b0 || arr_set !== 4'd2) begin errors++; $display("FAIL b2b restart busy/hit/set: got %b/%b/%0d exp 1/0/2", snoop_busy, snoop_hit, arr_set); end
        @(negedge clk);
        @(negedge clk);
        bus_command_command = 3'd0;
        #1;
        checks++; if (snoop_hit !== 1'b1 || snoop_dirty !== 1'b0 || arr_state_we !== 4'b0000) begin errors++; $display("FAIL b2b second hit/dirty/we: got %b/%b/%b exp 1/0/0000", snoop_hit, snoop_dirty, arr_state_we); end
        @(negedge clk);
        #1;
        checks++; if (snoop_busy !== 1'b0) begin errors++; $display("FAIL b2b idle busy: got %b exp 0", snoop_busy); end
    endtask

    task automatic test_reset_mid;
        set_way(4'd2, 2'd1, 23'd9, 2'd2);
        @(negedge clk);
        bus_command_address = ADDR_A; bus_command_command = 3'd1;
        @(negedge clk);
        rst = 1'b1; bus_command_command = 3'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (snoop_busy !== 1'b0 || snoop_hit !== 1'b0 || arr_state_we !== 4'b0000 || arr_set !== 4'd0) begin
            errors++; $display("FAIL rst_mid busy/hit/we/set: got %b/%b/%b/%0d exp 0/0/0000/0", snoop_busy, snoop_hit, arr_state_we, arr_set); end
        checks++; if (snoop_data !== '0 || snoop_dirty !== 1'b0) begin errors++; $display("FAIL rst_mid data/dirty: got %h/%b exp 0/0", snoop_data, snoop_dirty); end
        checks++; if (snoop_hit_count !== 32'd0 || snoop_inval_count !== 32'd0) begin errors++; $display("FAIL rst_mid counters: got %0d/%0d exp 0/0", snoop_hit_count, snoop_inval_count); end
        @(negedge clk);
        checks++; if (m_state[2][1] !== 2'd2) begin errors++; $display("FAIL rst_mid stored state: got %0d exp 2", m_state[2][1]); end
    endtask

    task automatic test_stats;
        logic [31:0] exp_hits, exp_invals;
`ifdef SNOOP_STATS_EN
        exp_hits = 32'd3; exp_invals = 32'd2;
`else
        exp_hits = 32'd0; exp_invals = 32'd0;
`endif
        run_snoop(ADDR_A, 3'd1, 1'b0);   // way1 M -> S
        checks++; if (c2_we !== 4'b0010 || c2_out !== 2'd1) begin errors++; $display("FAIL stats rd we/out: got %b/%0d exp 0010/1", c2_we, c2_out); end
        run_snoop(ADDR_A, 3'd2, 1'b0);   // way1 S -> I
        run_snoop(ADDR_A, 3'd2, 1'b0);   // way2 S -> I
        checks++; if (c2_hit !== 1'b1 || c2_we !== 4'b0100) begin errors++; $display("FAIL stats rdx2 hit/we: got %b/%b exp 1/0100", c2_hit, c2_we); end
        checks++; if (snoop_hit_count !== exp_hits) begin errors++; $display("FAIL stats hit_count: got %0d exp %0d", snoop_hit_count, exp_hits); end
        checks++; if (snoop_inval_count !== exp_invals) begin errors++; $display("FAIL stats inval_count: got %0d exp %0d", snoop_inval_count, exp_invals); end
    endtask

    initial begin
        test_reset();
        test_rd_shared();
        test_rd_modified();
        test_multi_hit_flush();
        test_rdx();
        test_upgr();
        test_ignored_cmds();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snoop_responder.md
# snoop_responder

Per-core snoop responder on the L1 data-cache side of the shared snoop bus. It decodes the command the bus drives, looks up the local tag/state/data arrays through a borrowed array port, and reports hit and line data to the bus in the response cycle. It also applies the MSI state change the command demands. One instance sits beside each of the ooo and ppl data caches.

## Interface
- Parameters:
- `SETS`, default 16: sets per way; the index is `$clog2(SETS)` bits taken at address bit 5 upward.
- `WAYS`, default 4: associativity.
- `TAG_W`, default 23: tag width, equal to 32 − 5 − index bits.
- Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `bus_command_address` in 32: snooped line address.
- `bus_command_command` in 3: 0 NONE, 1 BUS_RD, 2 BUS_RDX, 3 BUS_UPGR, 4 FLUSH; 5–7 are treated as NONE.
- `self_owner` in 1: this core owns the current bus transaction, so the command is ignored.
- `snoop_busy` out 1: the array port is borrowed; the local cache must not access the arrays this cycle.
- `arr_set` out `$clog2(SETS)`: set index to the arrays.
- `arr_tag_in[WAYS]` in `TAG_W`: tags, valid one cycle after `arr_set`.
- `arr_state_in[WAYS]` in 2: per-way state (0 I, 1 S, 2 M), valid one cycle after `arr_set`.
- `arr_data_in[WAYS]` in 256: line data, valid one cycle after `arr_set`.
- `arr_state_we[WAYS]` out 1: per-way state write enable.
- `arr_state_out` out 2: new state value.
- `snoop_hit` out 1: valid line matches, asserted in RESPOND.
- `snoop_dirty` out 1: the hit line was in M.
- `snoop_data` out 256: matched line, or 0 on a miss.

## Operation
- FSM states are IDLE, LOOKUP and RESPOND.
- IDLE → LOOKUP when the command is 1–4 and `self_owner` = 0.
  - On this edge, latch the address and command.
  - Drive `arr_set` from the live address.
- LOOKUP → RESPOND unconditionally.
  - In this state, `arr_set` comes from the latched address.
- RESPOND → IDLE unconditionally.
- Hit and way select:
  - A way hits when its tag equals the latched tag and its state ≠ I.
  - If more than one way hits, the lowest way index wins.
  - `snoop_hit`, `snoop_dirty` and `snoop_data` are combinational from the array outputs, and non-zero only in RESPOND.
- State update is written in RESPOND, only on a hit, to the hit way only:
  - BUS_RD: M→S, S stays S with no write.
  - BUS_RDX: →I.
  - BUS_UPGR: →I.
  - FLUSH: no write.
- `snoop_data` is driven on any hit. Data is meaningful to the requester only when `snoop_dirty` = 1.
- `snoop_busy` is asserted:
  - in IDLE in the cycle the IDLE→LOOKUP condition holds (combinational, so the cache yields that same cycle);
  - for all of LOOKUP and RESPOND.
- A command that stays asserted after RESPOND (the bus is back in its free state) is re-evaluated from IDLE like any other.

## Timing
- Bus contract: the command is held for two cycles (serve, then response), and the bus samples hit and data in the response cycle.
- Cycle alignment:
  - Cycle 0: command first seen, IDLE→LOOKUP condition true.
  - Cycle 1: LOOKUP, the bus is in its serve cycle.
  - Cycle 2: RESPOND; hit and data are driven to the bus.
- The array read is issued in cycle 0 and is re-driven with the same set in cycle 1, so a 1-cycle-latency SRAM output is valid in cycles 1 and 2.
- `arr_state_we` is a single-cycle pulse in RESPOND and commits at the end of cycle 2.
- Reset values: FSM = IDLE; latched address/command = 0; every output = 0, including `arr_set`.
- Reset mid-transaction: the FSM returns to IDLE next cycle, no state write is issued, and counters clear.
- Commands that change during LOOKUP or RESPOND are ignored; the latched values are used.
- Back-to-back snoops: minimum spacing is 3 cycles, enforced by the FSM.

## Configuration
- `SNOOP_STATS_EN`: when defined, the block adds 32-bit output counters:
  - `snoop_hit_count`: +1 per RESPOND with a hit.
  - `snoop_inval_count`: +1 per state write to I.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When the macro is undefined, the ports still exist, are tied to 0, and no counter flops are built.

## Test plan
- BUS_RD to 0x0000_1240 (set 2) with way 1 in S and a matching tag → RESPOND cycle shows hit = 1, dirty = 0, data = way 1 line; no `arr_state_we`.
- BUS_RD to the same address with way 3 in M → hit = 1, dirty = 1, data = way 3 line; `arr_state_we[3]` pulses with `arr_state_out` = S in cycle 2.
- BUS_RDX hit in S way 0 → `arr_state_we[0]` with state I. Repeat the same address → hit = 0, data = 0.
- `self_owner` = 1 with BUS_RD → `snoop_busy` stays 0; no lookup and no outputs.
- `rst` asserted in LOOKUP → next cycle IDLE, no state write, all outputs 0.
- With `SNOOP_STATS_EN`, run 3 hits, 2 of them RDX → `snoop_hit_count` = 3, `snoop_inval_count` = 2. Without the macro, both read 0.
